// File: rtl/requant_pack_ctrl.sv
// requant_pack_ctrl: output-stage sequencer for the conv datapath.
// Rounds and right-shifts signed accumulators, clamps them to OUTPUT_DW,
// packs PACK_N lanes per word and streams the words out with frame control.
// Optional build macro: REQUANT_RELU_EN (forces negative results to zero).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; cfg_* latched on start
// RUN    | accepting accumulators, packing lanes
// DRAIN  | final element accepted, waiting for the last word handshake
// DONE   | one-cycle frame-complete pulse

module requant_clamp #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  // Saturate to the signed output range; optionally rectify negatives.
  always_comb begin
    dout = din[OUT_W-1:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
`ifdef REQUANT_RELU_EN
    // Negative clamps are hidden by the rectifier, so they are not counted.
    if (din[IN_W-1]) begin
      dout = '0;
      sat  = 1'b0;
    end
`endif
  end

endmodule

module requant_pack_ctrl #(
  parameter int INPUT_DW  = 24,
  parameter int OUTPUT_DW = 8,
  parameter int PACK_N    = 4,
  parameter int SHIFT_W   = 5,
  parameter int LEN_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_W-1:0]            cfg_len,
  input  logic [SHIFT_W-1:0]          cfg_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INPUT_DW-1:0]         in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUTPUT_DW*PACK_N-1:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic [LEN_W-1:0]            sat_cnt
);

  localparam int LANE_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam int WORD_W = OUTPUT_DW * PACK_N;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [LEN_W-1:0]     sat_cnt_q, sat_cnt_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [WORD_W-1:0]    stage_q, stage_d;
  logic [WORD_W-1:0]    out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;

  logic signed [INPUT_DW:0] x_ext, rnd, sum, shifted;
  logic [OUTPUT_DW-1:0]     q_res;
  logic                     q_sat;
  logic                     in_ready_c, accept, last_elem, word_end, out_hs;
  logic [WORD_W-1:0]        packed_word;

  // Round-half-up arithmetic shift, one bit wider than the input so the
  // rounding add cannot overflow.
  always_comb begin
    x_ext = $signed({in_data[INPUT_DW-1], in_data});
    rnd   = '0;
    if (shift_q != '0) rnd = (INPUT_DW+1)'(1) << (shift_q - SHIFT_W'(1));
    sum     = x_ext + rnd;
    shifted = sum >>> shift_q;
  end

  requant_clamp #(
    .IN_W  (INPUT_DW + 1),
    .OUT_W (OUTPUT_DW)
  ) u_clamp (
    .din  (shifted),
    .dout (q_res),
    .sat  (q_sat)
  );

  // Handshake qualifiers and the word formed if this element closes it.
  always_comb begin
    out_hs     = out_valid_q && out_ready;
    in_ready_c = (state_q == S_RUN) && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready_c;
    last_elem  = (cnt_q == len_q - LEN_W'(1));
    word_end   = accept && (last_elem || (lane_q == LANE_W'(PACK_N - 1)));
    packed_word = stage_q;
    for (int i = 0; i < PACK_N; i++) begin
      if (lane_q == LANE_W'(i)) packed_word[i*OUTPUT_DW +: OUTPUT_DW] = q_res;
    end
  end

  // Next-state, counters, lane staging and output word register.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sat_cnt_d   = sat_cnt_q;
    shift_d     = shift_q;
    lane_d      = lane_q;
    stage_d     = stage_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          shift_d   = cfg_shift;
          sat_cnt_d = '0;
          cnt_d     = '0;
          lane_d    = '0;
          stage_d   = '0;
          state_d   = (cfg_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (q_sat && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + LEN_W'(1);
          if (word_end) begin
            stage_d = '0;
            lane_d  = '0;
          end else begin
            stage_d = packed_word;
            lane_d  = lane_q + LANE_W'(1);
          end
          if (last_elem) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_hs && out_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A new word loaded in the same cycle as a handshake keeps valid high.
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (word_end) begin
      out_valid_d = 1'b1;
      out_data_d  = packed_word;
      out_last_d  = last_elem;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      sat_cnt_q   <= '0;
      shift_q     <= '0;
      lane_q      <= '0;
      stage_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sat_cnt_q   <= sat_cnt_d;
      shift_q     <= shift_d;
      lane_q      <= lane_d;
      stage_q     <= stage_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign sat_cnt   = sat_cnt_q;

endmodule
